lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
//  Initiator side of the DPI memory port (ren/wen/raddr/rdata/waddr/wdata/mask).
//  Accepts one load/store request at a time from the EXU over valid/ready.
//  Issues one aligned 64-bit strobe to the memory block and returns
//  lane-extracted, sign/zero-extended load data (or a store ack) over valid/ready.
//  Sits between the execute stage and the pmem_read/pmem_write memory model.
// PARAMETERS
//  MEM_LAT  1  cycles the strobe is held high; rdata is captured on the last one (>=1)
// PORTS
//  clk          in   1   clock, all state updates on posedge
//  rst_n        in   1   synchronous reset, active low
//  req_valid    in   1   request present
//  req_ready    out  1   request accepted when valid&&ready
//  req_load     in   1   1=load, 0=store
//  req_addr     in   64  byte address
//  req_wdata    in   64  store data, right-justified
//  req_size     in   2   0=byte 1=half 2=word 3=dword
//  req_signed   in   1   loads: 1=sign-extend, 0=zero-extend
//  resp_valid   out  1   response present
//  resp_ready   in   1   response consumed when valid&&ready
//  resp_rdata   out  64  extended load data; 0 for stores and misaligned
//  resp_misalign out 1   address not aligned to size; no memory access made
//  mem_ren      out  1   read strobe to memory
//  mem_wen      out  1   write strobe to memory
//  mem_raddr    out  64  {addr[63:3],3'b0}
//  mem_rdata    in   64  aligned dword from memory
//  mem_waddr    out  64  {addr[63:3],3'b0}
//  mem_wdata    out  64  req_wdata << (addr[2:0]*8)
//  mem_mask     out  8   byte enables: size mask (0x01/0x03/0x0F/0xFF) << addr[2:0]
// BEHAVIOUR
//  - Reset: state IDLE, counter 0; all outputs 0 except req_ready=1 (IDLE).
//    Reset wins over every other event. Mid-ACCESS: strobes drop on the same
//    edge. Mid-RESP: the pending response is discarded.
//  - FSM IDLE -> ACCESS -> RESP -> IDLE. req_ready=1 only in IDLE.
//  - Accept (IDLE, req_valid): latch all req_* fields.
//    If misaligned, go to RESP with resp_misalign=1. Otherwise go to ACCESS
//    with counter=MEM_LAT-1.
//  - Misaligned means: half with addr[0]!=0; word with addr[1:0]!=0;
//    dword with addr[2:0]!=0.
//  - ACCESS: exactly one strobe high (ren for loads, wen for stores); the
//    other stays 0. Address, wdata and mask are stable from registers.
//    On the counter==0 cycle, capture mem_rdata (loads) and go to RESP;
//    otherwise decrement the counter.
//  - Strobes are 0 in IDLE and RESP. Back-to-back accesses are therefore
//    separated by >=2 low cycles, so the edge-sensitive memory sees exactly
//    one rising edge per access and performs one read/write.
//  - Load extract: d = rdata_q >> (addr[2:0]*8).
//    Byte, half and word are taken from d[7:0], d[15:0] and d[31:0] and
//    extended per req_signed. Dword is d unchanged.
//  - RESP: resp_valid=1. resp_rdata and resp_misalign are held stable until
//    resp_ready. On the ready cycle go to IDLE; the next request can be
//    accepted one cycle later.
//  - Latency, accept at edge T: strobes high T+1..T+MEM_LAT, resp_valid from
//    T+MEM_LAT+1. Misaligned: resp_valid from T+1.
//  - The memory-side address outputs hold their last value outside ACCESS.
//    Their reset value is 0.
// TESTING
//  1 Reset: assert rst_n=0 for 2 cycles during ACCESS -> mem_ren/mem_wen=0
//    on the next edge, resp_valid=0, req_ready=1 after release.
//  2 Store byte, addr 0x80000003, wdata 0xAB -> mem_wen high for 1 cycle,
//    waddr 0x80000000, mask 0x08, mem_wdata 0x00000000AB000000;
//    response rdata 0, misalign 0.
//  3 Load half signed, addr 0x80000006, mem_rdata 0x8123456789ABCDEF
//    -> resp_rdata 0xFFFFFFFFFFFF8123. Unsigned -> 0x0000000000008123.
//  4 Load word, addr 0x80000002 -> no ren pulse, resp_valid at T+1,
//    resp_misalign 1, rdata 0.
//  5 Two back-to-back loads, resp_ready low 3 cycles -> resp fields stable,
//    req_ready 0, ren low until the handshake; second load gets a fresh
//    rising edge.
//  6 MEM_LAT=3, load dword at 0x80000008 -> ren high T+1..T+3, data captured
//    at T+3, resp_valid at T+4.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// ----------------------------------------------------------------------------
// lsu_mem_ctrl_if
// Bundles the three buses around the LSU memory controller:
//   req_*  : EXU -> controller load/store request (valid/ready)
//   resp_* : controller -> EXU load data / store ack (valid/ready)
//   mem_*  : controller -> memory model strobes, aligned address, data, mask
// Modports:
//   slave  : the controller's view (consumes requests, drives memory side)
//   master : the environment's view (EXU plus memory model)
// ----------------------------------------------------------------------------
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_signed;

  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_misalign;

  logic        mem_ren;
  logic        mem_wen;
  logic [63:0] mem_raddr;
  logic [63:0] mem_rdata;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_mask;

  modport slave (
    input  req_valid, req_load, req_addr, req_wdata, req_size, req_signed,
    output req_ready,
    output resp_valid, resp_rdata, resp_misalign,
    input  resp_ready,
    output mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_mask,
    input  mem_rdata
  );

  modport master (
    output req_valid, req_load, req_addr, req_wdata, req_size, req_signed,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_misalign,
    output resp_ready,
    input  mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_mask,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// ----------------------------------------------------------------------------
// lsu_mem_ctrl
// Initiator side of the DPI memory port. Takes one load/store at a time from
// the EXU, issues a single aligned 64-bit strobe (ren or wen) to the memory
// model for MEM_LAT cycles, then returns lane-extracted, sign/zero-extended
// load data (or a zero store ack) on the response channel. Misaligned
// requests skip the memory entirely and respond with resp_misalign=1.
// Ports:
//   clk    : clock, all state updates on posedge
//   rst_n  : synchronous reset, active low
//   bus    : lsu_mem_ctrl_if.slave (req_*, resp_*, mem_* signals)
// Parameters:
//   MEM_LAT : cycles the strobe is held high; rdata captured on the last (>=1)
// ----------------------------------------------------------------------------
module lsu_mem_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_mem_ctrl_if.slave bus
);

  localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [CW-1:0] r_cnt;
  logic          r_load;
  logic          r_signed;
  logic [1:0]    r_size;
  logic [2:0]    r_off;
  logic [63:0]   r_maddr;
  logic [63:0]   r_mwdata;
  logic [7:0]    r_mmask;
  logic [63:0]   r_resp_rdata;
  logic          r_resp_misalign;

  logic          w_accept;
  logic          w_misalign;
  logic          w_last;
  logic [7:0]    w_size_mask;
  logic [63:0]   w_shifted;
  logic [63:0]   w_extracted;

  assign w_accept = (r_state == ST_IDLE) && bus.req_valid;
  assign w_last   = (r_cnt == '0);

  // Natural alignment check on the incoming request.
  always_comb begin
    w_misalign = 1'b0;
    case (bus.req_size)
      2'd1:    w_misalign = bus.req_addr[0];
      2'd2:    w_misalign = |bus.req_addr[1:0];
      2'd3:    w_misalign = |bus.req_addr[2:0];
      default: w_misalign = 1'b0;
    endcase
  end

  always_comb begin
    w_size_mask = 8'hFF;
    case (bus.req_size)
      2'd0:    w_size_mask = 8'h01;
      2'd1:    w_size_mask = 8'h03;
      2'd2:    w_size_mask = 8'h0F;
      default: w_size_mask = 8'hFF;
    endcase
  end

  // Lane extraction straight from the memory bus so the extended value can
  // be registered on the capture edge (last strobe cycle).
  assign w_shifted = bus.mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_extracted = w_shifted;
    case (r_size)
      2'd0: w_extracted = r_signed ? {{56{w_shifted[7]}},  w_shifted[7:0]}
                                   : {56'd0, w_shifted[7:0]};
      2'd1: w_extracted = r_signed ? {{48{w_shifted[15]}}, w_shifted[15:0]}
                                   : {48'd0, w_shifted[15:0]};
      2'd2: w_extracted = r_signed ? {{32{w_shifted[31]}}, w_shifted[31:0]}
                                   : {32'd0, w_shifted[31:0]};
      default: w_extracted = w_shifted;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and handshake/strobe outputs. Strobes are decoded from the
  // state register, so a reset edge drops them immediately.
  always_comb begin
    w_state_next   = r_state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.mem_ren    = 1'b0;
    bus.mem_wen    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          w_state_next = w_misalign ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        bus.mem_ren = r_load;
        bus.mem_wen = ~r_load;
        if (w_last) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Request latch, countdown and response capture. Memory-side address,
  // data and mask only change on an aligned accept, so they hold their last
  // value while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt           <= '0;
      r_load          <= 1'b0;
      r_signed        <= 1'b0;
      r_size          <= 2'd0;
      r_off           <= 3'd0;
      r_maddr         <= 64'd0;
      r_mwdata        <= 64'd0;
      r_mmask         <= 8'd0;
      r_resp_rdata    <= 64'd0;
      r_resp_misalign <= 1'b0;
    end else if (w_accept) begin
      r_load          <= bus.req_load;
      r_signed        <= bus.req_signed;
      r_size          <= bus.req_size;
      r_off           <= bus.req_addr[2:0];
      r_resp_rdata    <= 64'd0;
      r_resp_misalign <= w_misalign;
      if (!w_misalign) begin
        r_cnt    <= CNT_INIT;
        r_maddr  <= {bus.req_addr[63:3], 3'b000};
        r_mwdata <= bus.req_wdata << {bus.req_addr[2:0], 3'b000};
        r_mmask  <= w_size_mask << bus.req_addr[2:0];
      end
    end else if (r_state == ST_ACCESS) begin
      if (w_last) begin
        if (r_load) begin
          r_resp_rdata <= w_extracted;
        end
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign bus.mem_raddr     = r_maddr;
  assign bus.mem_waddr     = r_maddr;
  assign bus.mem_wdata     = r_mwdata;
  assign bus.mem_mask      = r_mmask;
  assign bus.resp_rdata    = r_resp_rdata;
  assign bus.resp_misalign = r_resp_misalign;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lsu_mem_ctrl
// Two controller instances (MEM_LAT=1 and MEM_LAT=3) on a shared clock and
// reset. Expected responses and expected memory strobes are queued when a
// request is driven; negedge monitors pop and compare them as the DUTs
// produce strobes and response handshakes. Inputs are driven 2 time units
// after posedge; outputs are sampled at negedge or 2 units after posedge.
// ----------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  lsu_mem_ctrl_if bus1 ();
  lsu_mem_ctrl_if bus3 ();

  // Memory model data: valid only while the read strobe is high, so a
  // capture on the wrong cycle picks up the poison pattern.
  logic [63:0] mdata1, mdata3;
  assign bus1.mem_rdata = bus1.mem_ren ? mdata1 : 64'hDEAD_BEEF_DEAD_BEEF;
  assign bus3.mem_rdata = bus3.mem_ren ? mdata3 : 64'hDEAD_BEEF_DEAD_BEEF;

  lsu_mem_ctrl #(.MEM_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  lsu_mem_ctrl #(.MEM_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  typedef struct packed {
    logic [63:0] rdata;
    logic        misalign;
  } resp_t;

  typedef struct packed {
    logic        is_wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
  } strb_t;

  resp_t resp_q1[$], resp_q3[$];
  strb_t strb_q1[$], strb_q3[$];

  int tests_run    = 0;
  int tests_failed = 0;
  int lat_of[2]    = '{1, 3};

  // monitor state per DUT
  logic        held[2]    = '{1'b0, 1'b0};
  logic [63:0] hold_d[2];
  logic        hold_m[2];
  logic        prev_s[2]  = '{1'b0, 1'b0};
  logic        aborted[2] = '{1'b0, 1'b0};
  int          hi_cnt[2]  = '{0, 0};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_mis(input logic [63:0] a, input logic [1:0] sz);
    int nb = 1 << sz;
    return (int'(a[2:0]) % nb) != 0;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] rd, input logic [63:0] a,
                                             input logic [1:0] sz, input logic sg);
    int nb = 1 << sz;
    int off = int'(a[2:0]);
    logic [63:0] v = 64'd0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
    if (sg && nb < 8 && v[8*nb-1]) begin
      for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
    end
    return v;
  endfunction

  function automatic logic [7:0] model_mask(input logic [63:0] a, input logic [1:0] sz);
    logic [7:0] m;
    case (sz)
      2'd0: m = 8'h01;
      2'd1: m = 8'h03;
      2'd2: m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << a[2:0];
  endfunction

  // ---------------- bus accessors ----------------
  function automatic logic get_ready(input int w);
    return (w == 0) ? bus1.req_ready : bus3.req_ready;
  endfunction
  function automatic logic get_rvalid(input int w);
    return (w == 0) ? bus1.resp_valid : bus3.resp_valid;
  endfunction

  task automatic set_req(input int w, input logic v, input logic ld, input logic [63:0] a,
                         input logic [63:0] wd, input logic [1:0] sz, input logic sg);
    if (w == 0) begin
      bus1.req_valid = v; bus1.req_load = ld; bus1.req_addr = a;
      bus1.req_wdata = wd; bus1.req_size = sz; bus1.req_signed = sg;
    end else begin
      bus3.req_valid = v; bus3.req_load = ld; bus3.req_addr = a;
      bus3.req_wdata = wd; bus3.req_size = sz; bus3.req_signed = sg;
    end
  endtask

  task automatic push_strb(input int w, input logic ld, input logic [63:0] a,
                           input logic [63:0] wd, input logic [1:0] sz);
    strb_t s;
    s.is_wr = ~ld;
    s.addr  = {a[63:3], 3'b000};
    s.wdata = wd << (int'(a[2:0]) * 8);
    s.mask  = model_mask(a, sz);
    if (w == 0) strb_q1.push_back(s); else strb_q3.push_back(s);
  endtask

  task automatic wait_ready(input int w);
    int n = 0;
    while (!get_ready(w) && n < 50) begin @(posedge clk); #2; n++; end
    check_eq("req_ready_wait", {63'd0, get_ready(w)}, 64'd1);
  endtask

  // Drive one request, queue its expectations, and check accept->resp_valid latency.
  task automatic do_req(input int w, input logic ld, input logic [63:0] a, input logic [63:0] wd,
                        input logic [1:0] sz, input logic sg, input logic [63:0] md,
                        input logic [63:0] exp_d, input logic exp_m);
    resp_t r;
    int n;
    wait_ready(w);
    r.rdata = exp_d;
    r.misalign = exp_m;
    if (w == 0) resp_q1.push_back(r); else resp_q3.push_back(r);
    if (!exp_m) push_strb(w, ld, a, wd, sz);
    if (w == 0) mdata1 = md; else mdata3 = md;
    set_req(w, 1'b1, ld, a, wd, sz, sg);
    @(posedge clk); #2;
    set_req(w, 1'b0, 1'b0, 64'd0, 64'd0, 2'd0, 1'b0);
    n = 1;
    while (!get_rvalid(w) && n < 20) begin @(posedge clk); #2; n++; end
    check_eq("resp_latency", 64'(n), exp_m ? 64'd1 : 64'(lat_of[w] + 1));
  endtask

  task automatic wait_idle(input int w);
    int n = 0;
    while (!(get_ready(w) && !get_rvalid(w)) && n < 50) begin @(posedge clk); #2; n++; end
    check_eq("idle_wait", {63'd0, get_ready(w)}, 64'd1);
  endtask

  // ---------------- monitors ----------------
  task automatic mon_resp(input int w, input logic rstn, input logic v, input logic rdy,
                          input logic [63:0] d, input logic m);
    resp_t e;
    int sz;
    if (!rstn) begin
      held[w] = 1'b0;
    end else if (v) begin
      if (held[w]) begin
        check_eq("resp_hold_rdata", d, hold_d[w]);
        check_eq("resp_hold_misalign", {63'd0, m}, {63'd0, hold_m[w]});
      end
      if (rdy) begin
        sz = (w == 0) ? resp_q1.size() : resp_q3.size();
        check_eq("resp_pending", {63'd0, sz > 0}, 64'd1);
        if (sz > 0) begin
          e = (w == 0) ? resp_q1.pop_front() : resp_q3.pop_front();
          $display("[TB] dut%0d resp rdata=0x%016h misalign=%0d (exp 0x%016h/%0d)",
                   lat_of[w], d, m, e.rdata, e.misalign);
          check_eq("resp_rdata", d, e.rdata);
          check_eq("resp_misalign", {63'd0, m}, {63'd0, e.misalign});
        end
        held[w] = 1'b0;
      end else begin
        held[w]   = 1'b1;
        hold_d[w] = d;
        hold_m[w] = m;
      end
    end
  endtask

  task automatic mon_strb(input int w, input logic rstn, input logic ren, input logic wen,
                          input logic [63:0] ra, input logic [63:0] wa,
                          input logic [63:0] wd, input logic [7:0] mk);
    strb_t e;
    int sz;
    logic s = ren | wen;
    if (!rstn) aborted[w] = 1'b1;
    if (s) check_eq("strb_exclusive", {63'd0, ren & wen}, 64'd0);
    if (s && !prev_s[w]) begin
      sz = (w == 0) ? strb_q1.size() : strb_q3.size();
      check_eq("strb_pending", {63'd0, sz > 0}, 64'd1);
      if (sz > 0) begin
        e = (w == 0) ? strb_q1.pop_front() : strb_q3.pop_front();
        check_eq("strb_kind", {63'd0, wen}, {63'd0, e.is_wr});
        check_eq("strb_addr", wen ? wa : ra, e.addr);
        check_eq("strb_mask", {56'd0, mk}, {56'd0, e.mask});
        if (e.is_wr) check_eq("strb_wdata", wd, e.wdata);
      end
      hi_cnt[w]  = 1;
      aborted[w] = !rstn;
    end else if (s) begin
      hi_cnt[w]++;
    end else if (prev_s[w] && !aborted[w]) begin
      check_eq("strb_width", 64'(hi_cnt[w]), 64'(lat_of[w]));
    end
    prev_s[w] = s;
  endtask

  always @(negedge clk) begin
    mon_resp(0, rst_n, bus1.resp_valid, bus1.resp_ready, bus1.resp_rdata, bus1.resp_misalign);
    mon_resp(1, rst_n, bus3.resp_valid, bus3.resp_ready, bus3.resp_rdata, bus3.resp_misalign);
    mon_strb(0, rst_n, bus1.mem_ren, bus1.mem_wen, bus1.mem_raddr, bus1.mem_waddr,
             bus1.mem_wdata, bus1.mem_mask);
    mon_strb(1, rst_n, bus3.mem_ren, bus3.mem_wen, bus3.mem_raddr, bus3.mem_waddr,
             bus3.mem_wdata, bus3.mem_mask);
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic        ld, sg, mis;
    logic [1:0]  sz;
    logic [63:0] a, wd, md, ex;
    int          w;

    rst_n  = 1'b0;
    mdata1 = 64'd0;
    mdata3 = 64'd0;
    set_req(0, 1'b0, 1'b0, 64'd0, 64'd0, 2'd0, 1'b0);
    set_req(1, 1'b0, 1'b0, 64'd0, 64'd0, 2'd0, 1'b0);
    bus1.resp_ready = 1'b1;
    bus3.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;

    // reset state
    check_eq("rst_req_ready",  {63'd0, bus1.req_ready},  64'd1);
    check_eq("rst_resp_valid", {63'd0, bus1.resp_valid}, 64'd0);
    check_eq("rst_ren",        {63'd0, bus1.mem_ren},    64'd0);
    check_eq("rst_wen",        {63'd0, bus1.mem_wen},    64'd0);
    check_eq("rst_raddr",      bus1.mem_raddr,           64'd0);
    check_eq("rst_wdata",      bus1.mem_wdata,           64'd0);
    check_eq("rst_mask",       {56'd0, bus1.mem_mask},   64'd0);
    check_eq("rst_resp_rdata", bus3.resp_rdata,          64'd0);
    check_eq("rst_misalign",   {63'd0, bus3.resp_misalign}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // store byte
    do_req(0, 1'b0, 64'h8000_0003, 64'hAB, 2'd0, 1'b0, 64'd0, 64'd0, 1'b0);
    // load half signed / unsigned
    do_req(0, 1'b1, 64'h8000_0006, 64'd0, 2'd1, 1'b1, 64'h8123_4567_89AB_CDEF,
           64'hFFFF_FFFF_FFFF_8123, 1'b0);
    do_req(0, 1'b1, 64'h8000_0006, 64'd0, 2'd1, 1'b0, 64'h8123_4567_89AB_CDEF,
           64'h0000_0000_0000_8123, 1'b0);
    // misaligned word, half, dword
    do_req(0, 1'b1, 64'h8000_0002, 64'd0, 2'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    do_req(0, 1'b0, 64'h8000_0005, 64'h1234, 2'd1, 1'b0, 64'd0, 64'd0, 1'b1);
    do_req(1, 1'b1, 64'h8000_000C, 64'd0, 2'd3, 1'b0, 64'd0, 64'd0, 1'b1);
    // signed byte at top lane, signed word at upper half
    do_req(0, 1'b1, 64'h8000_0017, 64'd0, 2'd0, 1'b1, 64'h80FF_0000_0000_0000,
           64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    do_req(0, 1'b1, 64'h8000_0004, 64'd0, 2'd2, 1'b1, 64'h8000_0001_7FFF_FFFF,
           64'hFFFF_FFFF_8000_0001, 1'b0);
    wait_idle(0);

    // back-to-back loads with a stalled response
    bus1.resp_ready = 1'b0;
    do_req(0, 1'b1, 64'h8000_0020, 64'd0, 2'd3, 1'b0, 64'h0102_0304_0506_0708,
           64'h0102_0304_0506_0708, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_req_ready", {63'd0, bus1.req_ready}, 64'd0);
      check_eq("stall_ren",       {63'd0, bus1.mem_ren},   64'd0);
      @(posedge clk); #2;
    end
    bus1.resp_ready = 1'b1;
    do_req(0, 1'b1, 64'h8000_0021, 64'd0, 2'd0, 1'b0, 64'h0000_0000_0000_9900,
           64'h0000_0000_0000_0099, 1'b0);
    wait_idle(0);

    // MEM_LAT=3 dword load and a store
    do_req(1, 1'b1, 64'h8000_0008, 64'd0, 2'd3, 1'b0, 64'hCAFE_F00D_1234_5678,
           64'hCAFE_F00D_1234_5678, 1'b0);
    do_req(1, 1'b0, 64'h8000_0012, 64'h0000_0000_DEAD_5EED, 2'd1, 1'b0, 64'd0, 64'd0, 1'b0);
    wait_idle(1);

    // random mix on both instances
    for (int i = 0; i < 24; i++) begin
      w   = i % 2;
      ld  = 1'($urandom_range(0, 1));
      sg  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      a   = 64'h8000_0000 + 64'($urandom_range(0, 127));
      wd  = {$urandom, $urandom};
      md  = {$urandom, $urandom};
      mis = model_mis(a, sz);
      ex  = (!mis && ld) ? model_load(md, a, sz, sg) : 64'd0;
      do_req(w, ld, a, wd, sz, sg, md, ex, mis);
    end
    wait_idle(0);
    wait_idle(1);

    // reset in the middle of an access on the MEM_LAT=3 instance
    wait_ready(1);
    push_strb(1, 1'b1, 64'h8000_0010, 64'd0, 2'd3);
    mdata3 = 64'h5555_AAAA_5555_AAAA;
    set_req(1, 1'b1, 1'b1, 64'h8000_0010, 64'd0, 2'd3, 1'b0);
    @(posedge clk); #2;
    set_req(1, 1'b0, 1'b0, 64'd0, 64'd0, 2'd0, 1'b0);
    check_eq("mid_access_ren", {63'd0, bus3.mem_ren}, 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #2;
    check_eq("rst_mid_ren",        {63'd0, bus3.mem_ren},    64'd0);
    check_eq("rst_mid_wen",        {63'd0, bus3.mem_wen},    64'd0);
    check_eq("rst_mid_resp_valid", {63'd0, bus3.resp_valid}, 64'd0);
    check_eq("rst_mid_raddr",      bus3.mem_raddr,           64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      check_eq("post_rst_req_ready",  {63'd0, bus3.req_ready},  64'd1);
      check_eq("post_rst_resp_valid", {63'd0, bus3.resp_valid}, 64'd0);
    end

    // normal operation resumes after reset
    do_req(1, 1'b1, 64'h8000_0018, 64'd0, 2'd2, 1'b1, 64'h0000_0000_FFFF_FFFE,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    wait_idle(1);
    repeat (3) @(posedge clk);
    #2;
    check_eq("resp_q1_drained", 64'(resp_q1.size()), 64'd0);
    check_eq("resp_q3_drained", 64'(resp_q3.size()), 64'd0);
    check_eq("strb_q1_drained", 64'(strb_q1.size()), 64'd0);
    check_eq("strb_q3_drained", 64'(strb_q3.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
